// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the packed-float / linear converter pair.
// Packed float word layout is {sign, exp[EXP_W-1:0], sig[SIG_W-1:0]}.
package fpcvt_pkg;

    localparam int FP_EXP_W = 3;
    localparam int FP_SIG_W = 4;
    localparam int FP_OUT_W = 12;

    // Bit positions of each field inside the packed float word
    localparam int PF_SIG_LSB  = 0;
    localparam int PF_EXP_LSB  = PF_SIG_LSB + FP_SIG_W;
    localparam int PF_SIGN_POS = PF_EXP_LSB + FP_EXP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_decode_sign_restore.sv
// Combinational sign restore: magnitude plus sign bit to two's complement.
// A negative sign on a zero magnitude yields plain zero.
module sign_restore #(
    parameter int W = 12
) (
    input  logic         i_sgn,
    input  logic [W-1:0] i_mag,
    output logic [W-1:0] o_val
);

    assign o_val = (i_sgn && (i_mag != '0)) ? (~i_mag + W'(1)) : i_mag;

endmodule

// File: rtl/fp_decode.sv
// Packed float {sign, exp, sig} to two's-complement linear decoder.
// FP_DECODE_FAST_EN selects a single-cycle barrel shift instead of the serial shifter.
module fp_decode
    import fpcvt_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int SIG_W = FP_SIG_W,
    parameter int OUT_W = FP_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    state_t             r_state, w_state_next;
    logic [OUT_W-1:0]   r_out_data, w_out_data_next;
    logic               w_sr_sgn;
    logic [OUT_W-1:0]   w_sr_mag;
    logic [OUT_W-1:0]   w_sr_val;

`ifndef FP_DECODE_FAST_EN
    logic [OUT_W-1:0]   r_mag, w_mag_next;
    logic [EXP_W-1:0]   r_cnt, w_cnt_next;
    logic               r_sgn, w_sgn_next;

    assign w_sr_sgn = r_sgn;
    assign w_sr_mag = r_mag;
`else
    assign w_sr_sgn = in_sign;
    assign w_sr_mag = OUT_W'(in_sig) << in_exp;
`endif

    sign_restore #(.W(OUT_W)) u_sign_restore (
        .i_sgn (w_sr_sgn),
        .i_mag (w_sr_mag),
        .o_val (w_sr_val)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;

    always_comb begin
        w_state_next    = r_state;
        w_out_data_next = r_out_data;
`ifndef FP_DECODE_FAST_EN
        w_mag_next      = r_mag;
        w_cnt_next      = r_cnt;
        w_sgn_next      = r_sgn;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef FP_DECODE_FAST_EN
                    w_out_data_next = w_sr_val;
                    w_state_next    = HOLD;
`else
                    w_mag_next   = OUT_W'(in_sig);
                    w_cnt_next   = in_exp;
                    w_sgn_next   = in_sign;
                    w_state_next = (in_exp != '0) ? SHIFT : SIGN;
`endif
                end
            end
`ifndef FP_DECODE_FAST_EN
            SHIFT: begin
                // cnt==1 marks the last shift; the magnitude never overflows OUT_W
                w_mag_next = r_mag << 1;
                w_cnt_next = r_cnt - EXP_W'(1);
                if (r_cnt == EXP_W'(1)) begin
                    w_state_next = SIGN;
                end
            end
            SIGN: begin
                w_out_data_next = w_sr_val;
                w_state_next    = HOLD;
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_out_data <= '0;
`ifndef FP_DECODE_FAST_EN
            r_mag      <= '0;
            r_cnt      <= '0;
            r_sgn      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_out_data <= w_out_data_next;
`ifndef FP_DECODE_FAST_EN
            r_mag      <= w_mag_next;
            r_cnt      <= w_cnt_next;
            r_sgn      <= w_sgn_next;
`endif
        end
    end

endmodule
